// File: rtl/snake_pkg.sv
// Shared grid definitions for the snake game and its food generator.
package snake_pkg;

    localparam int GRID_W = 7;
    localparam int GRID_H = 6;
    localparam int CELLS  = GRID_W * GRID_H;

    typedef logic [5:0] cell_idx_t;
    typedef logic [2:0] coord_t;

    // Linear cell index y*7+x, built as (y<<3)-y+x so no multiplier is needed
    function automatic cell_idx_t cell_index(input coord_t x, input coord_t y);
        cell_idx_t y_wide;
        y_wide = {3'b000, y};
        return (y_wide << 3) - y_wide + {3'b000, x};
    endfunction

endpackage

// File: rtl/snake_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used as the food position source.
module snake_lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    output logic [7:0] o_Value
);

    logic [7:0] value_q;
    logic [7:0] value_d;
    logic       feedback;

    // Next state: shift left and feed back the XOR of the tap bits
    always_comb begin
        feedback = value_q[7] ^ value_q[5] ^ value_q[4] ^ value_q[3];
        value_d  = {value_q[6:0], feedback};
    end

    // Register advances every clock; a non-zero seed keeps it out of the all-zero lockup
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            value_q <= SEED;
        end else begin
            value_q <= value_d;
        end
    end

    assign o_Value = value_q;

endmodule

// File: rtl/snake_food_gen.sv
// Picks a pseudo-random free grid cell for new food by scanning from an LFSR-derived start cell.
module snake_food_gen
    import snake_pkg::cell_idx_t;
    import snake_pkg::coord_t;
    import snake_pkg::cell_index;
#(
    parameter int         GRID_W    = 7,
    parameter int         GRID_H    = 6,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    input  logic                     i_Req,
    input  logic [GRID_W*GRID_H-1:0] i_Occupancy,
    output logic [2:0]               o_Food_X,
    output logic [2:0]               o_Food_Y,
    output logic                     o_Valid,
    output logic                     o_Busy,
    output logic                     o_Grid_Full
);

    localparam int CELLS = GRID_W * GRID_H;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    logic [0:0] state_q, state_d;
    coord_t     x_q, x_d;
    coord_t     y_q, y_d;
    logic [5:0] probe_q, probe_d;
    coord_t     food_x_q, food_x_d;
    coord_t     food_y_q, food_y_d;
    logic       valid_q, valid_d;
    logic       full_q, full_d;

    logic [7:0] lfsr_value;
    logic       lfsr_unused;
    coord_t     lfsr_x;
    coord_t     lfsr_y;
    cell_idx_t  probe_idx;
    logic       probe_occupied;

    snake_lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .o_Value (lfsr_value)
    );

    // Only the low six LFSR bits pick the start cell
    assign lfsr_unused = ^lfsr_value[7:6];
    assign lfsr_x      = lfsr_value[2:0];
    assign lfsr_y      = lfsr_value[5:3];

    // Occupancy is sampled live at the cell currently being probed
    assign probe_idx      = cell_index(x_q, y_q);
    assign probe_occupied = i_Occupancy[probe_idx];

    // Scan FSM: latch start cell on request, then walk row-major until a free cell or a full lap
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        probe_d  = probe_q;
        food_x_d = food_x_q;
        food_y_d = food_y_q;
        valid_d  = 1'b0;
        full_d   = full_q;
        case (state_q)
            ST_IDLE: begin
                if (i_Req) begin
                    x_d     = (lfsr_x >= coord_t'(GRID_W)) ? lfsr_x - coord_t'(GRID_W) : lfsr_x;
                    y_d     = (lfsr_y >= coord_t'(GRID_H)) ? lfsr_y - coord_t'(GRID_H) : lfsr_y;
                    full_d  = 1'b0;
                    probe_d = 6'd0;
                    state_d = ST_SCAN;
                end
            end
            default: begin
                if (!probe_occupied) begin
                    food_x_d = x_q;
                    food_y_d = y_q;
                    valid_d  = 1'b1;
                    state_d  = ST_IDLE;
                end else if (probe_q == 6'(CELLS - 1)) begin
                    full_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    probe_d = probe_q + 6'd1;
                    if (x_q == coord_t'(GRID_W - 1)) begin
                        x_d = 3'd0;
                        y_d = (y_q == coord_t'(GRID_H - 1)) ? 3'd0 : y_q + 3'd1;
                    end else begin
                        x_d = x_q + 3'd1;
                    end
                end
            end
        endcase
    end

    // State and output registers; reset aborts any scan in progress
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q  <= ST_IDLE;
            x_q      <= 3'd0;
            y_q      <= 3'd0;
            probe_q  <= 6'd0;
            food_x_q <= 3'd0;
            food_y_q <= 3'd0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            probe_q  <= probe_d;
            food_x_q <= food_x_d;
            food_y_q <= food_y_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
        end
    end

    assign o_Food_X    = food_x_q;
    assign o_Food_Y    = food_y_q;
    assign o_Valid     = valid_q;
    assign o_Busy      = (state_q == ST_SCAN);
    assign o_Grid_Full = full_q;

endmodule

// File: tb/tb_snake_food_gen.sv
// Self-checking bench for snake_food_gen: directed table, corner sequences and random requests.
module tb_snake_food_gen;

    localparam logic [7:0] SEED = 8'hA5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [41:0] occ = '0;
    logic [2:0]  food_x;
    logic [2:0]  food_y;
    logic        valid;
    logic        busy;
    logic        grid_full;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  lfsr_m;
    int          last_x = 0;
    int          last_y = 0;

    typedef struct {
        logic [41:0] occ;
        int          lat;
        bit          full;
        int          x;
        int          y;
        string       name;
    } vec_t;

    vec_t vecs[4];

    snake_food_gen dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_Req       (req),
        .i_Occupancy (occ),
        .o_Food_X    (food_x),
        .o_Food_Y    (food_y),
        .o_Valid     (valid),
        .o_Busy      (busy),
        .o_Grid_Full (grid_full)
    );

    always #5 clk = ~clk;

    // Reference LFSR step: shift left, new bit is parity of taps 8,6,5,4
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    // Reference placement: walk the linear cell order mod 42 from the start cell
    task automatic predict(input logic [41:0] o, input logic [7:0] l,
                           output int lat, output bit full, output int x, output int y);
        int start;
        int c;
        start = (int'(l[5:3]) % 6) * 7 + (int'(l[2:0]) % 7);
        lat = 43;
        full = 1'b1;
        x = last_x;
        y = last_y;
        for (int p = 0; p < 42; p++) begin
            c = (start + p) % 42;
            if (!o[c]) begin
                lat = p + 2;
                full = 1'b0;
                x = c % 7;
                y = c / 7;
                break;
            end
        end
    endtask

    // Advance one clock, keep the reference LFSR aligned, then settle past the edge
    task automatic tick();
        @(posedge clk);
        lfsr_m = rst ? SEED : lfsr_next(lfsr_m);
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        last_x = 0;
        last_y = 0;
    endtask

    // Issue one request in the current cycle and follow it to its outcome cycle
    task automatic applyStimulus(input logic [41:0] o, input int lat, input bit full,
                                 input int x, input int y, input string name);
        occ = o;
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int c = 1; c < lat; c++) begin
            checkOutput({name, "_busy"}, int'(busy), 1);
            checkOutput({name, "_valid_early"}, int'(valid), 0);
            if (c == 1) checkOutput({name, "_full_clr"}, int'(grid_full), 0);
            tick();
        end
        checkOutput({name, "_valid"}, int'(valid), full ? 0 : 1);
        checkOutput({name, "_busy_done"}, int'(busy), 0);
        checkOutput({name, "_full"}, int'(grid_full), int'(full));
        checkOutput({name, "_x"}, int'(food_x), x);
        checkOutput({name, "_y"}, int'(food_y), y);
        last_x = x;
        last_y = y;
    endtask

    task automatic applyModel(input logic [41:0] o, input string name);
        int lat;
        bit full;
        int x;
        int y;
        predict(o, lfsr_m, lat, full, x, y);
        applyStimulus(o, lat, full, x, y, name);
    endtask

    initial begin
        int vcount;
        logic [63:0] r;
        logic [41:0] ro;

        vecs[0] = '{42'h0, 2, 1'b0, 5, 4, "empty"};
        vecs[1] = '{(42'd1 << 33) | (42'd1 << 34), 4, 1'b0, 0, 5, "occ_start"};
        vecs[2] = '{{{41{1'b1}}, 1'b0}, 11, 1'b0, 0, 0, "wrap"};
        vecs[3] = '{{42{1'b1}}, 43, 1'b1, 0, 0, "full"};

        $display("[TB] start");
        doReset();
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_valid", int'(valid), 0);
        checkOutput("rst_full", int'(grid_full), 0);
        checkOutput("rst_x", int'(food_x), 0);
        checkOutput("rst_y", int'(food_y), 0);

        // Directed table: each vector requests in the first cycle after reset (L = A5)
        for (int i = 0; i < 4; i++) begin
            doReset();
            applyStimulus(vecs[i].occ, vecs[i].lat, vecs[i].full, vecs[i].x, vecs[i].y, vecs[i].name);
        end
        // Follow-up to the full grid: the next request clears the sticky flag
        applyModel(42'h0, "after_full");

        // Request while busy is ignored: exactly one valid pulse
        doReset();
        occ = (42'd1 << 33) | (42'd1 << 34);
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        req = 1'b1;
        tick();
        req = 1'b0;
        checkOutput("busyreq_busy", int'(busy), 1);
        tick();
        checkOutput("busyreq_valid", int'(valid), 1);
        checkOutput("busyreq_x", int'(food_x), 0);
        checkOutput("busyreq_y", int'(food_y), 5);
        vcount = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (valid || busy) vcount++;
        end
        checkOutput("busyreq_no_second", vcount, 0);

        // Reset in the middle of a full-grid scan
        doReset();
        applyStimulus(42'h0, 2, 1'b0, 5, 4, "pre_abort");
        occ = {42{1'b1}};
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_full", int'(grid_full), 0);
        checkOutput("abort_valid", int'(valid), 0);
        checkOutput("abort_x", int'(food_x), 0);
        checkOutput("abort_y", int'(food_y), 0);
        last_x = 0;
        last_y = 0;
        applyStimulus(42'h0, 2, 1'b0, 5, 4, "post_abort");

        // Reset and request in the same cycle: reset wins
        rst = 1'b1;
        req = 1'b1;
        tick();
        rst = 1'b0;
        req = 1'b0;
        last_x = 0;
        last_y = 0;
        checkOutput("rstreq_busy", int'(busy), 0);
        checkOutput("rstreq_x", int'(food_x), 0);
        applyStimulus(42'h0, 2, 1'b0, 5, 4, "rstreq_next");

        // Random occupancy and request gaps against the reference model
        for (int n = 0; n < 40; n++) begin
            r = {$urandom(), $urandom()} | {$urandom(), $urandom()};
            ro = r[41:0];
            if ($urandom_range(0, 5) == 0) ro = {42{1'b1}};
            if ($urandom_range(0, 3) == 0) ro = ro | {$urandom(), $urandom()};
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
            applyModel(ro, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
